// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_PEND,
    SRC_BR,
    SRC_RET,
    SRC_JMP,
    SRC_SEQ
  } src_e;

  // Mask that clears the low log2(inc) bits; inc is a power of two.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;

  assign top   = mem[ptr - PW'(1)];
  assign empty = (count == '0);
  assign full  = (count == CW'(RAS_DEPTH));

  // ptr always names the next slot to write; a full push lands on the oldest entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (pop) begin
      if (!empty) begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop && !flush) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC with prioritised redirects, a stall-time pending buffer,
// a return-address stack and wrap-to-reset past the text-segment limit.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h80,
  parameter logic [WIDTH-1:0] TEXT_LIMIT   = 76,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             WriteEnable,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             JumpTaken,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Call,
  input  logic             Return,
  input  logic             Exception,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RedirectPending,
  output logic             RASEmpty,
  output logic             RASFull,
  output logic             Wrapped
);

  localparam logic [WIDTH-1:0] AMASK = WIDTH'(align_mask(INC));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_tgt;
  logic             pend_vld;
  logic             pend_exc;
  logic             wrapped_q;

  logic [WIDTH-1:0] br_tgt, jmp_tgt, exc_tgt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_full;
  logic             ras_push, ras_pop, ras_flush;

  src_e             src;
  logic [WIDTH-1:0] cand;
  logic             apply_exc;
  logic             wrap;
  logic [WIDTH-1:0] next_pc;

  assign br_tgt  = BranchTarget & AMASK;
  assign jmp_tgt = JumpTarget & AMASK;
  assign exc_tgt = EXC_VECTOR & AMASK;
  assign PCPlus  = pc_q + WIDTH'(INC);

  always_comb begin
    src  = SRC_SEQ;
    cand = PCPlus;
    if (Exception) begin
      src  = SRC_EXC;
      cand = exc_tgt;
    end else if (pend_vld) begin
      src  = SRC_PEND;
      cand = pend_tgt;
    end else if (BranchTaken) begin
      src  = SRC_BR;
      cand = br_tgt;
    end else if (JumpTaken && Return && !ras_empty) begin
      src  = SRC_RET;
      cand = ras_top;
    end else if (JumpTaken) begin
      src  = SRC_JMP;
      cand = jmp_tgt;
    end
  end

  // The exception handler lives outside the text segment, so it is exempt from the wrap check.
  assign apply_exc = (src == SRC_EXC) || ((src == SRC_PEND) && pend_exc);
  assign wrap      = !apply_exc && (cand > TEXT_LIMIT);
  assign next_pc   = wrap ? RESET_VECTOR : cand;

  assign ras_push  = WriteEnable && (src == SRC_JMP) && Call && !Return;
  assign ras_pop   = WriteEnable && (src == SRC_RET);
  assign ras_flush = WriteEnable && apply_exc;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_q      <= RESET_VECTOR;
      pend_vld  <= 1'b0;
      pend_exc  <= 1'b0;
      wrapped_q <= 1'b0;
    end else if (WriteEnable) begin
      pc_q      <= next_pc;
      pend_vld  <= 1'b0;
      pend_exc  <= 1'b0;
      wrapped_q <= wrap;
    end else begin
      wrapped_q <= 1'b0;
      if (Exception) begin
        pend_vld <= 1'b1;
        pend_exc <= 1'b1;
      end else if (!pend_vld && (BranchTaken || JumpTaken)) begin
        pend_vld <= 1'b1;
        pend_exc <= 1'b0;
      end
    end
  end

  // Target storage carries no reset; it is only meaningful while pend_vld is set.
  always_ff @(posedge Clock) begin
    if (!WriteEnable) begin
      if (Exception)                      pend_tgt <= exc_tgt;
      else if (!pend_vld && BranchTaken)  pend_tgt <= br_tgt;
      else if (!pend_vld && JumpTaken)    pend_tgt <= jmp_tgt;
    end
  end

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (Clock),
    .rst_n(Reset),
    .push (ras_push),
    .pop  (ras_pop),
    .flush(ras_flush),
    .din  (PCPlus),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

  assign PC              = pc_q;
  assign RedirectPending = pend_vld;
  assign RASEmpty        = ras_empty;
  assign RASFull         = ras_full;
  assign Wrapped         = wrapped_q;

endmodule
